// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between mc_ctrl and the instruction/data memory ports.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_rdy;
    logic ir_wr;
    logic dmem_req;
    logic dmem_we;
    logic dmem_rdy;

    modport master (
        output imem_req,
        output ir_wr,
        output dmem_req,
        output dmem_we,
        input  imem_rdy,
        input  dmem_rdy
    );

    modport slave (
        input  imem_req,
        input  ir_wr,
        input  dmem_req,
        input  dmem_we,
        output imem_rdy,
        output dmem_rdy
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with
// ready/valid memory handshakes and a bounded wait timeout.
// Optional build macro MC_CTRL_PERF_EN adds cycle/retire counters.
module mc_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5,
    parameter int unsigned ALUCTR_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    mc_ctrl_if.master           mem,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                overflow,
    output logic                pc_wr,
    output logic [1:0]          npc_sel,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src,
    output logic [1:0]          ext_op,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic [2:0]          state,
    output logic                illegal,
    output logic                bus_err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]         cyc_cnt,
    output logic [31:0]         ret_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [2:0] ALU_SLT  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_NONE = 3'b111;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_q;
    logic            ovf_q;
    logic            timeout_c;

    logic       legal, is_r_alu, is_jr, is_j, is_jal, is_beq, is_lw, is_sw, is_addi;
    logic       alu_src_dec;
    logic [1:0] ext_op_dec;
    logic [2:0] alu_ctr_dec;

    assign timeout_c = (wait_q == TO_W'(TIMEOUT_CYCLES));
    assign state     = 3'(state_q);

    // Instruction decode of the IR fields into class flags and ALU controls.
    always_comb begin
        legal       = 1'b1;
        is_r_alu    = 1'b0;
        is_jr       = 1'b0;
        is_j        = 1'b0;
        is_jal      = 1'b0;
        is_beq      = 1'b0;
        is_lw       = 1'b0;
        is_sw       = 1'b0;
        is_addi     = 1'b0;
        alu_src_dec = 1'b0;
        ext_op_dec  = 2'b00;
        alu_ctr_dec = ALU_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: begin is_r_alu = 1'b1; alu_ctr_dec = ALU_ADD; end
                    FN_SUBU: begin is_r_alu = 1'b1; alu_ctr_dec = ALU_SUB; end
                    FN_SLT:  begin is_r_alu = 1'b1; alu_ctr_dec = ALU_SLT; end
                    FN_JR:   is_jr = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_ORI: begin
                alu_src_dec = 1'b1;
                alu_ctr_dec = ALU_OR;
            end
            OP_LUI: begin
                alu_src_dec = 1'b1;
                ext_op_dec  = 2'b10;
                alu_ctr_dec = ALU_LUI;
            end
            OP_ADDIU, OP_ADDI, OP_LW, OP_SW: begin
                alu_src_dec = 1'b1;
                ext_op_dec  = 2'b01;
                alu_ctr_dec = ALU_ADD;
                is_addi     = (opcode == OP_ADDI);
                is_lw       = (opcode == OP_LW);
                is_sw       = (opcode == OP_SW);
            end
            OP_BEQ: begin
                is_beq      = 1'b1;
                ext_op_dec  = 2'b01;
                alu_ctr_dec = ALU_SUB;
            end
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            default: legal  = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d      = state_q;
        mem.imem_req = 1'b0;
        mem.ir_wr    = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        pc_wr        = 1'b0;
        npc_sel      = 2'b00;
        reg_write    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_src      = 1'b0;
        ext_op       = 2'b00;
        alu_ctr      = ALUCTR_W'(ALU_NONE);
        illegal      = 1'b0;
        bus_err      = 1'b0;
        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            alu_src = alu_src_dec;
            ext_op  = ext_op_dec;
            alu_ctr = ALUCTR_W'(alu_ctr_dec);
        end
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem.imem_rdy) begin
                    mem.imem_req = 1'b1;
                    mem.ir_wr    = 1'b1;
                    state_d      = DECODE;
                end else if (timeout_c) begin
                    bus_err = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem.imem_req = 1'b1;
                end
            end
            DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = FETCH;
                end else if (is_j) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b10;
                    state_d = FETCH;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b11;
                    state_d = FETCH;
                end else if (is_jal) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = MEM;
                end else if (is_beq) begin
                    pc_wr   = 1'b1;
                    npc_sel = zero ? 2'b01 : 2'b00;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem.dmem_rdy) begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = is_sw;
                    if (is_sw) begin
                        pc_wr   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout_c) begin
                    bus_err = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = is_sw;
                end
            end
            WB: begin
                reg_write = is_addi ? !ovf_q : 1'b1;
                pc_wr     = 1'b1;
                if (is_jal) begin
                    npc_sel    = 2'b10;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end else begin
                    reg_dst    = is_r_alu ? 2'b01 : 2'b00;
                    mem_to_reg = is_lw ? 2'b01 : 2'b00;
                end
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake wait counter: restarts on every state change or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_d != state_q || bus_err) begin
            wait_q <= '0;
        end else if ((mem.imem_req && !mem.imem_rdy) || (mem.dmem_req && !mem.dmem_rdy)) begin
            wait_q <= wait_q + TO_W'(1);
        end
    end

    // Overflow captured at the end of EXEC for the addi write-back decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == EXEC) begin
            ovf_q <= overflow;
        end
    end

`ifdef MC_CTRL_PERF_EN
    // Active-cycle and retired-instruction counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state_q != IDLE) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (pc_wr && !illegal && !bus_err) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
